// File: rtl/vga_rx.sv
// ---------------------------------------------------------------------------
// vga_rx : VGA timing receiver / pixel capture front end.
//
// Samples an incoming VGA stream (separate active-low hs/vs plus 4:4:4 RGB),
// rebuilds the horizontal/vertical position from the sync edges, checks that
// the raster timing is stable, and once locked emits one write per
// 2^UNIT_WIDTH x 2^UNIT_WIDTH block of active pixels toward a pixel RAM.
//
// Ports
//   vga_clk      in   pixel clock, rising edge
//   rst          in   asynchronous, active-low reset
//   hs, vs       in   active-low sync pulses
//   r, g, b      in   4-bit colour components, sampled every clock
//   we           out  write strobe toward pixel RAM (one clock per pixel)
//   wr_col_addr  out  pixel RAM column  = col[9:UNIT_WIDTH]
//   wr_row_addr  out  pixel RAM row     = row[8:UNIT_WIDTH]
//   dout         out  pixel data packed {b,g,r}
//   locked       out  high while the raster timing is verified
//   frame_start  out  one-clock pulse per accepted frame
//
// Configuration
//   VGA_RX_SYNC_EN  when defined, a second input register stage is added in
//                   front of all decisions (pin-to-we latency 3 instead of 2).
//   UNIT_WIDTH / COL_WIDTH / ROW_WIDTH macros size the RAM address ports.
//   Timing parameters default to the standard 800x525 raster.
// ---------------------------------------------------------------------------
`ifndef UNIT_WIDTH
`define UNIT_WIDTH 3
`endif
`ifndef COL_WIDTH
`define COL_WIDTH (10-`UNIT_WIDTH)
`endif
`ifndef ROW_WIDTH
`define ROW_WIDTH (9-`UNIT_WIDTH)
`endif

module vga_rx #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_ACT_START = 143,
    parameter int H_ACT_END   = 782,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 514
) (
    input  logic                   vga_clk,
    input  logic                   rst,
    input  logic                   hs,
    input  logic                   vs,
    input  logic [3:0]             r,
    input  logic [3:0]             g,
    input  logic [3:0]             b,
    output logic                   we,
    output logic [`COL_WIDTH-1:0]  wr_col_addr,
    output logic [`ROW_WIDTH-1:0]  wr_row_addr,
    output logic [11:0]            dout,
    output logic                   locked,
    output logic                   frame_start
);

    localparam int U  = `UNIT_WIDTH;
    localparam int SW = 14;                 // {hs, vs, b, g, r}

`ifdef VGA_RX_SYNC_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    // Syncs reset to 1 (idle) so leaving reset never fakes a falling edge.
    localparam logic [SW-1:0] PIPE_RST = {1'b1, 1'b1, 12'h000};

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input register stage(s). Colour travels with the syncs so pixel data
    // stays aligned with the position derived from them.
    // ------------------------------------------------------------------
    logic [SW-1:0]        bus_in;
    logic [STAGES*SW-1:0] pipe_reg;
    logic [STAGES*SW-1:0] pipe_next;
    logic [SW-1:0]        smp;

    assign bus_in = {hs, vs, b, g, r};

`ifdef VGA_RX_SYNC_EN
    assign pipe_next = {pipe_reg[SW-1:0], bus_in};
`else
    assign pipe_next = bus_in;
`endif

    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            pipe_reg <= {STAGES{PIPE_RST}};
        end else begin
            pipe_reg <= pipe_next;
        end
    end

    assign smp = pipe_reg[STAGES*SW-1 -: SW];

    logic        hs_smp;
    logic        vs_smp;
    logic [11:0] pix_smp;

    assign hs_smp  = smp[13];
    assign vs_smp  = smp[12];
    assign pix_smp = smp[11:0];

    // ------------------------------------------------------------------
    // Edge detection on the decision stage.
    // ------------------------------------------------------------------
    logic hs_prev_reg;
    logic vs_prev_reg;
    logic hs_fe;
    logic vs_fe;

    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            hs_prev_reg <= 1'b1;
            vs_prev_reg <= 1'b1;
        end else begin
            hs_prev_reg <= hs_smp;
            vs_prev_reg <= vs_smp;
        end
    end

    assign hs_fe = hs_prev_reg & ~hs_smp;
    assign vs_fe = vs_prev_reg & ~vs_smp;

    // ------------------------------------------------------------------
    // Position counters. hc_cur/vc_cur are the coordinates of the sample
    // now in the decision stage; hc_reg/vc_reg hold those of the previous
    // sample, which is what the line/frame length checks look at.
    // ------------------------------------------------------------------
    logic [9:0] hc_reg;
    logic [9:0] vc_reg;
    logic [9:0] hc_cur;
    logic [9:0] vc_cur;

    always_comb begin
        hc_cur = (hc_reg == 10'd1023) ? hc_reg : hc_reg + 10'd1;
        if (hs_fe) begin
            hc_cur = 10'd0;
        end

        vc_cur = vc_reg;
        if (vs_fe) begin
            vc_cur = 10'd0;
        end else if (hs_fe && vc_reg != 10'd1023) begin
            vc_cur = vc_reg + 10'd1;
        end
    end

    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            hc_reg <= 10'd0;
            vc_reg <= 10'd0;
        end else begin
            hc_reg <= hc_cur;
            vc_reg <= vc_cur;
        end
    end

    logic [9:0] col;
    logic [8:0] row;
    logic       active;
    logic       unit_hit;
    logic       line_ok;
    logic       frame_ok;

    assign col      = hc_cur - 10'(H_ACT_START);
    assign row      = 9'(vc_cur - 10'(V_ACT_START));
    assign active   = (hc_cur >= 10'(H_ACT_START)) && (hc_cur <= 10'(H_ACT_END)) &&
                      (vc_cur >= 10'(V_ACT_START)) && (vc_cur <= 10'(V_ACT_END));
    assign unit_hit = (col[U-1:0] == '0) && (row[U-1:0] == '0);
    assign line_ok  = (hc_reg == 10'(H_TOTAL - 1));
    assign frame_ok = (vc_reg == 10'(V_TOTAL - 1));

    // ------------------------------------------------------------------
    // Lock FSM.
    // ------------------------------------------------------------------
    state_t state_reg;
    state_t state_next;
    logic   bad_reg;
    logic   bad_next;
    logic   timing_err;
    logic   frame_acc;

    always_comb begin
        state_next = state_reg;
        bad_next   = bad_reg;
        timing_err = 1'b0;
        frame_acc  = 1'b0;
        case (state_reg)
            SEARCH: begin
                if (vs_fe && hs_fe) begin
                    state_next = ALIGN;
                    bad_next   = 1'b0;
                end
            end
            ALIGN: begin
                // A bad line on the very sample of the closing vs FE also
                // counts against this frame.
                if (hs_fe && !line_ok) begin
                    bad_next = 1'b1;
                end
                if (vs_fe) begin
                    if (!bad_next && frame_ok) begin
                        state_next = LOCKED;
                        frame_acc  = 1'b1;
                    end
                    bad_next = 1'b0;
                end
            end
            LOCKED: begin
                timing_err = (hs_fe && !line_ok) ||
                             (hc_cur == 10'd1023) ||
                             (vs_fe && !hs_fe) ||
                             (vs_fe && !frame_ok);
                if (timing_err) begin
                    state_next = SEARCH;
                end else if (vs_fe) begin
                    frame_acc = 1'b1;
                end
            end
            default: begin
                state_next = SEARCH;
            end
        endcase
    end

    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            state_reg <= SEARCH;
            bad_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            bad_reg   <= bad_next;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs. The sample that trips a timing error is never
    // written even though the FSM is still LOCKED on it.
    // ------------------------------------------------------------------
    logic                  we_reg;
    logic [`COL_WIDTH-1:0] col_addr_reg;
    logic [`ROW_WIDTH-1:0] row_addr_reg;
    logic [11:0]           dout_reg;
    logic                  locked_reg;
    logic                  frame_start_reg;

    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            we_reg          <= 1'b0;
            col_addr_reg    <= '0;
            row_addr_reg    <= '0;
            dout_reg        <= 12'h000;
            locked_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            we_reg          <= (state_reg == LOCKED) && !timing_err && active && unit_hit;
            col_addr_reg    <= col[9:U];
            row_addr_reg    <= row[8:U];
            dout_reg        <= pix_smp;
            locked_reg      <= (state_next == LOCKED);
            frame_start_reg <= frame_acc;
        end
    end

    assign we          = we_reg;
    assign wr_col_addr = col_addr_reg;
    assign wr_row_addr = row_addr_reg;
    assign dout        = dout_reg;
    assign locked      = locked_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_rx.sv
// ---------------------------------------------------------------------------
// tb_vga_rx : scoreboard bench for vga_rx.
//
// A compact raster (176 clocks x 22 lines, active hc 143..174, vc 3..18) is
// generated so that locking, full frames and recovery fit in a short run.
// The stimulus pushes every expected RAM write into a queue as the pixel is
// driven; an independent monitor pops and compares on each we pulse.
// ---------------------------------------------------------------------------
module tb_vga_rx;

    localparam int HT  = 176;
    localparam int VT  = 22;
    localparam int HA0 = 143;
    localparam int HA1 = 174;
    localparam int VA0 = 3;
    localparam int VA1 = 18;
    localparam int HSW = 16;

    logic        vga_clk = 1'b0;
    logic        rst     = 1'b0;
    logic        hs      = 1'b1;
    logic        vs      = 1'b1;
    logic [3:0]  r       = 4'h0;
    logic [3:0]  g       = 4'h0;
    logic [3:0]  b       = 4'h0;
    logic        we;
    logic [6:0]  wr_col_addr;
    logic [5:0]  wr_row_addr;
    logic [11:0] dout;
    logic        locked;
    logic        frame_start;

    always #20 vga_clk = ~vga_clk;

    vga_rx #(
        .H_TOTAL     (HT),
        .V_TOTAL     (VT),
        .H_ACT_START (HA0),
        .H_ACT_END   (HA1),
        .V_ACT_START (VA0),
        .V_ACT_END   (VA1)
    ) dut (
        .vga_clk     (vga_clk),
        .rst         (rst),
        .hs          (hs),
        .vs          (vs),
        .r           (r),
        .g           (g),
        .b           (b),
        .we          (we),
        .wr_col_addr (wr_col_addr),
        .wr_row_addr (wr_row_addr),
        .dout        (dout),
        .locked      (locked),
        .frame_start (frame_start)
    );

    int          n_vec  = 0;
    int          n_err  = 0;
    int          wr_cnt = 0;
    int          fs_cnt = 0;
    int          fs_exp = 0;
    int          n0     = 0;
    bit          exp_wr = 1'b0;
    logic [24:0] exp_q[$];
    logic [24:0] mon_e;
    logic [6:0]  last_col = '0;
    logic [5:0]  last_row = '0;

    function automatic logic [11:0] pix(input int h, input int v);
        logic [11:0] t;
        t = 12'(h * 7 + v * 131);
        return t ^ 12'h5a3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_we"},          32'(we),          32'd0);
        check({pfx, "_col"},         32'(wr_col_addr), 32'd0);
        check({pfx, "_row"},         32'(wr_row_addr), 32'd0);
        check({pfx, "_dout"},        32'(dout),        32'd0);
        check({pfx, "_locked"},      32'(locked),      32'd0);
        check({pfx, "_frame_start"}, 32'(frame_start), 32'd0);
    endtask

    // Drive samples h0..h1 of raster line v; queue the writes a locked
    // receiver has to produce for them.
    task automatic drive_span(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) begin
            @(negedge vga_clk);
            hs = (h < HSW) ? 1'b0 : 1'b1;
            vs = (v < 2) ? 1'b0 : 1'b1;
            {b, g, r} = pix(h, v);
            if (exp_wr && h >= HA0 && h <= HA1 && v >= VA0 && v <= VA1 &&
                ((h - HA0) % 8) == 0 && ((v - VA0) % 8) == 0) begin
                exp_q.push_back({7'((h - HA0) / 8), 6'((v - VA0) / 8), pix(h, v)});
            end
        end
    endtask

    task automatic drive_lines(input int v0, input int v1);
        for (int v = v0; v <= v1; v++) begin
            drive_span(v, 0, HT - 1);
        end
    endtask

    // Monitor: scoreboard pop on each write, plus frame_start counting.
    always @(negedge vga_clk) begin
        if (frame_start) begin
            fs_cnt++;
        end
        if (we) begin
            wr_cnt++;
            last_col = wr_col_addr;
            last_row = wr_row_addr;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got col=%0d row=%0d dout=%h, expected no write",
                         wr_col_addr, wr_row_addr, dout);
            end else begin
                mon_e = exp_q.pop_front();
                if ({wr_col_addr, wr_row_addr, dout} !== mon_e) begin
                    n_err++;
                    $display("FAIL write_data: got col=%0d row=%0d dout=%h, expected col=%0d row=%0d dout=%h",
                             wr_col_addr, wr_row_addr, dout, mon_e[24:18], mon_e[17:12], mon_e[11:0]);
                end
            end
        end
    end

    initial begin
        // Reset state.
        rst = 1'b0;
        repeat (3) @(negedge vga_clk);
        check_outputs_zero("reset");
        rst = 1'b1;

        // Frame A: ALIGN frame, nothing written.
        exp_wr = 1'b0;
        n0 = wr_cnt;
        drive_lines(0, VT - 1);
        check("align_locked", 32'(locked), 32'd0);
        check("align_fs", 32'(fs_cnt), 32'(fs_exp));
        check("align_writes", 32'(wr_cnt - n0), 32'd0);

        // Frame B: second vs FE locks and pulses frame_start.
        exp_wr = 1'b1;
        fs_exp++;
        n0 = wr_cnt;
        drive_span(0, 0, 5);
        check("lock_rise", 32'(locked), 32'd1);
        check("lock_fs", 32'(fs_cnt), 32'(fs_exp));
        drive_span(0, 6, HT - 1);
        drive_lines(1, VT - 1);
        check("frame_b_writes", 32'(wr_cnt - n0), 32'd8);

        // Frame C: full locked frame, last write at the bottom-right unit.
        fs_exp++;
        n0 = wr_cnt;
        drive_lines(0, VT - 1);
        check("frame_c_writes", 32'(wr_cnt - n0), 32'd8);
        check("frame_c_last_col", 32'(last_col), 32'd3);
        check("frame_c_last_row", 32'(last_row), 32'd1);
        check("frame_c_fs", 32'(fs_cnt), 32'(fs_exp));

        // Frame D: line 3 is one clock short; lock drops on the next hs FE.
        fs_exp++;
        n0 = wr_cnt;
        drive_lines(0, 2);
        drive_span(3, 0, HT - 2);
        check("short_before", 32'(locked), 32'd1);
        exp_wr = 1'b0;
        drive_span(4, 0, 5);
        check("short_drop", 32'(locked), 32'd0);
        drive_span(4, 6, HT - 1);
        drive_lines(5, VT - 1);
        check("short_writes", 32'(wr_cnt - n0), 32'd4);

        // Frame E: clean ALIGN frame, still no writes.
        n0 = wr_cnt;
        drive_lines(0, VT - 1);
        check("realign_locked", 32'(locked), 32'd0);
        check("realign_writes", 32'(wr_cnt - n0), 32'd0);
        check("realign_fs", 32'(fs_cnt), 32'(fs_exp));

        // Frame F: relocked.
        exp_wr = 1'b1;
        fs_exp++;
        n0 = wr_cnt;
        drive_lines(0, VT - 1);
        check("relock_locked", 32'(locked), 32'd1);
        check("relock_writes", 32'(wr_cnt - n0), 32'd8);
        check("relock_fs", 32'(fs_cnt), 32'(fs_exp));

        // Frame G: hs held high for 1100 clocks on line 5; hc saturates.
        fs_exp++;
        n0 = wr_cnt;
        drive_lines(0, 4);
        check("pre_long_locked", 32'(locked), 32'd1);
        exp_wr = 1'b0;
        drive_span(5, 0, HSW + 1099);
        check("hc_sat_drop", 32'(locked), 32'd0);
        check("hc_sat_writes", 32'(wr_cnt - n0), 32'd4);

        // Frames H (ALIGN) and I (locked).
        n0 = wr_cnt;
        drive_lines(0, VT - 1);
        check("sat_align_locked", 32'(locked), 32'd0);
        check("sat_align_writes", 32'(wr_cnt - n0), 32'd0);
        exp_wr = 1'b1;
        fs_exp++;
        n0 = wr_cnt;
        drive_lines(0, VT - 1);
        check("sat_relock_locked", 32'(locked), 32'd1);
        check("sat_relock_writes", 32'(wr_cnt - n0), 32'd8);

        // Frame J: reset for 3 clocks in the middle of an active line.
        fs_exp++;
        n0 = wr_cnt;
        drive_lines(0, 2);
        drive_span(3, 0, 150);
        check("pre_rst_locked", 32'(locked), 32'd1);
        rst = 1'b0;
        @(negedge vga_clk);
        @(negedge vga_clk);
        check_outputs_zero("mid_rst");
        @(negedge vga_clk);
        rst = 1'b1;
        exp_wr = 1'b0;
        drive_span(3, 151, HT - 1);
        drive_lines(4, VT - 1);
        // Frame K: ALIGN after reset, no writes yet.
        drive_lines(0, VT - 1);
        check("rst_align_locked", 32'(locked), 32'd0);
        check("rst_writes", 32'(wr_cnt - n0), 32'd1);

        // Frame L: locked again.
        exp_wr = 1'b1;
        fs_exp++;
        n0 = wr_cnt;
        drive_lines(0, VT - 1);
        check("rst_relock_locked", 32'(locked), 32'd1);
        check("rst_relock_writes", 32'(wr_cnt - n0), 32'd8);
        check("final_fs", 32'(fs_cnt), 32'(fs_exp));

        repeat (5) @(negedge vga_clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
